// File: rtl/pipe_mux_nsel.sv
// Registered N-way operand selector with valid/ready handshake and a 2-entry skid buffer.
// Out-of-range selects yield DEFAULT and latch a sticky error flag.
module pipe_mux_nsel #(
  parameter int               WIDTH   = 32,
  parameter int               N_IN    = 4,
  parameter int               SEL_W   = 2,
  parameter logic [WIDTH-1:0] DEFAULT = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  err_sel,
  input  logic                  clr_err,
  output logic [1:0]            state_dbg
);

  // Handshake: a word moves on any rising edge where valid and ready are both 1;
  // the producer holds in_bus/sel while in_valid=1 and in_ready=0, and out_data
  // is held while out_valid=1 and out_ready=0.

  // Encoding equals the number of buffered words.
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] sel_word;
  logic             sel_bad;
  logic             accept, pop;

  always_comb begin
    sel_word = DEFAULT;
    for (int i = 0; i < N_IN; i++) begin
      if (32'(sel) == i) sel_word = in_bus[i*WIDTH +: WIDTH];
    end
  end

  assign sel_bad   = (32'(sel) >= N_IN);
  assign in_ready  = ~rst & (state_q != S_FULL);
  assign out_valid = (state_q == S_ONE) | (state_q == S_FULL);
  assign out_data  = main_q;
  assign err_sel   = err_q;
  assign state_dbg = state_q;
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          state_d = S_ONE;
          main_d  = sel_word;
        end
      end
      S_ONE: begin
        if (accept && pop) begin
          main_d = sel_word;
        end else if (accept) begin
          state_d = S_FULL;
          skid_d  = sel_word;
        end else if (pop) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (pop) begin
          state_d = S_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // A new bad accept outranks a coincident clear.
  always_comb begin
    err_d = err_q;
    if (accept && sel_bad) err_d = 1'b1;
    else if (clr_err)      err_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_pipe_mux_nsel.sv
// Bench for pipe_mux_nsel: three parameterisations run in lockstep against a
// queue-based reference model, with directed sequences followed by random traffic.
module tb_pipe_mux_nsel;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, out_ready, clr_err;
  logic [127:0] in_bus;
  logic [3:0]   sel;

  wire  [2:0]   ir, ov, er;
  wire  [31:0]  od_a, od_b;
  wire  [7:0]   od_c;
  wire  [1:0]   st_a, st_b, st_c;

  int n_cmp = 0;
  int n_err = 0;

  logic [95:0] exp_q[$];
  logic [2:0]  err_m;

  localparam logic [127:0] D_BUS = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};

  // Instance 0: 32-bit 4-way; 1: 32-bit 3-way with DEFAULT; 2: 8-bit 16-way.
  pipe_mux_nsel #(.WIDTH(32), .N_IN(4), .SEL_W(2), .DEFAULT(32'h0)) u_a (
    .clk(clk), .rst(rst), .in_bus(in_bus), .sel(sel[1:0]), .in_valid(in_valid),
    .in_ready(ir[0]), .out_data(od_a), .out_valid(ov[0]), .out_ready(out_ready),
    .err_sel(er[0]), .clr_err(clr_err), .state_dbg(st_a));

  pipe_mux_nsel #(.WIDTH(32), .N_IN(3), .SEL_W(2), .DEFAULT(32'hDEADBEEF)) u_b (
    .clk(clk), .rst(rst), .in_bus(in_bus[95:0]), .sel(sel[1:0]), .in_valid(in_valid),
    .in_ready(ir[1]), .out_data(od_b), .out_valid(ov[1]), .out_ready(out_ready),
    .err_sel(er[1]), .clr_err(clr_err), .state_dbg(st_b));

  pipe_mux_nsel #(.WIDTH(8), .N_IN(16), .SEL_W(4), .DEFAULT(8'h0)) u_c (
    .clk(clk), .rst(rst), .in_bus(in_bus), .sel(sel), .in_valid(in_valid),
    .in_ready(ir[2]), .out_data(od_c), .out_valid(ov[2]), .out_ready(out_ready),
    .err_sel(er[2]), .clr_err(clr_err), .state_dbg(st_c));

  always #5 clk = ~clk;

  function automatic logic [31:0] od_of(int k);
    return (k == 0) ? od_a : (k == 1) ? od_b : {24'h0, od_c};
  endfunction

  function automatic logic [31:0] st_of(int k);
    return (k == 0) ? {30'h0, st_a} : (k == 1) ? {30'h0, st_b} : {30'h0, st_c};
  endfunction

  function automatic int idx_of(int k, logic [3:0] s);
    return (k == 2) ? int'(s) : int'(s[1:0]);
  endfunction

  function automatic bit is_bad(int k, logic [3:0] s);
    int n;
    n = (k == 0) ? 4 : (k == 1) ? 3 : 16;
    return idx_of(k, s) >= n;
  endfunction

  // Reference select: bit-shift the bus by index*width and keep one word.
  function automatic logic [31:0] ref_sel(int k, logic [127:0] bus, logic [3:0] s);
    int w;
    logic [127:0] sh;
    w = (k == 2) ? 8 : 32;
    if (is_bad(k, s)) return (k == 1) ? 32'hDEADBEEF : 32'h0;
    sh = bus >> (idx_of(k, s) * w);
    return (w == 8) ? {24'h0, sh[7:0]} : sh[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs after a falling edge, update the model at the
  // rising edge, then compare every instance on the following falling edge.
  task automatic step(input logic v, input logic [3:0] s, input logic ordy, input logic clr);
    bit acc, pp;
    logic [95:0] word;
    in_valid  = v;
    sel       = s;
    out_ready = ordy;
    clr_err   = clr;
    #1;
    for (int k = 0; k < 3; k++)
      check($sformatf("in_ready%0d", k), {31'h0, ir[k]}, {31'h0, exp_q.size() < 2});
    acc  = v && (exp_q.size() < 2);
    pp   = ordy && (exp_q.size() > 0);
    word = {ref_sel(2, in_bus, s), ref_sel(1, in_bus, s), ref_sel(0, in_bus, s)};
    @(posedge clk);
    if (pp) void'(exp_q.pop_front());
    if (acc) exp_q.push_back(word);
    for (int k = 0; k < 3; k++) begin
      if (acc && is_bad(k, s)) err_m[k] = 1'b1;
      else if (clr)            err_m[k] = 1'b0;
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("out_valid%0d", k), {31'h0, ov[k]}, {31'h0, exp_q.size() > 0});
      check($sformatf("err_sel%0d", k), {31'h0, er[k]}, {31'h0, err_m[k]});
      check($sformatf("occupancy%0d", k), st_of(k), exp_q.size());
      if (exp_q.size() > 0)
        check($sformatf("out_data%0d", k), od_of(k), exp_q[0][k*32 +: 32]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_in_ready%0d", tag, k), {31'h0, ir[k]}, 32'h0);
      check($sformatf("%s_out_valid%0d", tag, k), {31'h0, ov[k]}, 32'h0);
      check($sformatf("%s_err%0d", tag, k), {31'h0, er[k]}, 32'h0);
      check($sformatf("%s_out_data%0d", tag, k), od_of(k), 32'h0);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_err = 1'b0;
    in_bus = '0; sel = '0; err_m = '0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) check($sformatf("ready_after_reset%0d", k), {31'h0, ir[k]}, 32'h1);

    // Single word, select 2.
    in_bus = D_BUS;
    step(1'b1, 4'd2, 1'b1, 1'b0);
    check("single_data", od_a, 32'h22222222);
    check("single_valid", {31'h0, ov[0]}, 32'h1);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    check("single_drained", {31'h0, ov[0]}, 32'h0);

    // Streaming at full rate.
    for (int s = 0; s < 4; s++) begin
      step(1'b1, 4'(s), 1'b1, 1'b0);
      check($sformatf("stream%0d", s), od_a, D_BUS[s*32 +: 32]);
    end
    step(1'b0, 4'd0, 1'b1, 1'b0);

    // Backpressure into FULL, then drain.
    step(1'b1, 4'd1, 1'b0, 1'b0);
    step(1'b1, 4'd3, 1'b0, 1'b0);
    check("bp_full_data", od_a, 32'h11111111);
    check("bp_full_ready", {31'h0, ir[0]}, 32'h0);
    step(1'b1, 4'd0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    check("bp_second", od_a, 32'h33333333);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    check("bp_ready_back", {31'h0, ir[0]}, 32'h1);

    // Out-of-range select on the 3-way instance.
    step(1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b1, 4'd3, 1'b1, 1'b0);
    check("oor_default", od_b, 32'hDEADBEEF);
    check("oor_err_set", {31'h0, er[1]}, 32'h1);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    check("oor_err_sticky", {31'h0, er[1]}, 32'h1);
    step(1'b0, 4'd0, 1'b1, 1'b1);
    check("oor_err_clr", {31'h0, er[1]}, 32'h0);
    step(1'b1, 4'd3, 1'b1, 1'b1);
    check("oor_set_wins", {31'h0, er[1]}, 32'h1);
    step(1'b0, 4'd0, 1'b1, 1'b0);

    // Asynchronous reset while FULL.
    step(1'b1, 4'd3, 1'b0, 1'b0);
    step(1'b1, 4'd1, 1'b0, 1'b0);
    check("pre_reset_full", st_of(0), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async");
    exp_q.delete();
    err_m = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) check($sformatf("ready_after_async%0d", k), {31'h0, ir[k]}, 32'h1);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      in_bus = {$urandom, $urandom, $urandom, $urandom};
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
    end
    for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_mux_nsel.md
# pipe_mux_nsel

- Parametrised, registered N-way operand selector with a valid/ready handshake and a 2-entry skid buffer.
- Next generation of the datapath's fixed 32-bit 4-way combinational select:
  - width and input count are parameters;
  - the selected word is captured into a pipeline register;
  - backpressure is supported;
  - out-of-range selects return a default value and raise a sticky error flag.
- Sits between register-file/ALU operand sources and a consumer stage that may stall.

## Interface
- WIDTH, 32, data word width in bits
- N_IN, 4, number of data inputs (2..16)
- SEL_W, 2, select width; must satisfy 2**SEL_W >= N_IN
- DEFAULT, 0, WIDTH-bit value produced when sel >= N_IN
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_bus  input  N_IN*WIDTH  concatenated inputs; input i occupies bits [i*WIDTH +: WIDTH]
- sel  input  SEL_W  input index, sampled with in_valid
- in_valid  input  1  producer has a word/select pair this cycle
- in_ready  output  1  block can accept this cycle
- out_data  output  WIDTH  selected word at head of buffer
- out_valid  output  1  out_data is valid
- out_ready  input  1  consumer takes out_data this cycle
- err_sel  output  1  sticky flag: an out-of-range select was accepted
- clr_err  input  1  synchronous clear of err_sel

## Operation
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- Selected word:
  - in_bus slice [sel*WIDTH +: WIDTH] when sel < N_IN;
  - otherwise DEFAULT.
- Storage: main register (drives out_data) and skid register.
- State machine EMPTY / ONE / FULL:
  - EMPTY:
    - accept -> ONE, main <= selected word.
  - ONE:
    - accept & pop -> ONE, main <= new word;
    - accept & !pop -> FULL, skid <= new word;
    - pop & !accept -> EMPTY;
    - neither -> hold.
  - FULL:
    - no accept possible;
    - pop -> ONE, main <= skid;
    - otherwise hold.
- Port decode from state:
  - in_ready = 1 in EMPTY and ONE, 0 in FULL and while rst is high;
  - out_valid = 1 in ONE and FULL.
- Order preserved: words leave in accept order; none dropped or duplicated.
- err_sel:
  - set on the edge where accept occurs with sel >= N_IN;
  - cleared by clr_err;
  - if set and clr_err coincide, set wins;
  - a rejected (not accepted) bad select does not set it.
- in_bus and sel are ignored when accept is 0.
- The combinational select uses only in_bus, sel and parameters; no stale-sensitivity behaviour.

## Timing
- Reset (async, immediate on rst rise):
  - state EMPTY, main = 0, skid = 0;
  - out_valid = 0, out_data = 0, err_sel = 0, in_ready = 0 while rst is high;
  - in_ready = 1 in the first cycle after rst falls.
- Latency: a word accepted at edge k appears on out_data with out_valid = 1 immediately after edge k when the buffer was EMPTY. Otherwise it appears after the preceding words pop.
- Throughput: one word per cycle sustained when out_ready is held 1.
- in_ready depends only on registered state; no combinational path from out_ready to in_ready.
- out_data is stable while out_valid = 1 and out_ready = 0.
- FULL with simultaneous pop:
  - in_ready is 0 that cycle, so no accept;
  - the next cycle is ONE and in_ready = 1.
- Reset asserted mid-transfer:
  - buffered words are discarded;
  - outputs go to reset values without waiting for clk.

## Test plan
- Reset, then in_bus = {D3,D2,D1,D0} = {0x33333333, 0x22222222, 0x11111111, 0x00000000}, sel = 2, in_valid = 1 for one cycle, out_ready = 1 -> out_data = 0x22222222, out_valid = 1 one edge later, then out_valid = 0.
- Streaming: sel = 0,1,2,3 on consecutive cycles, out_ready = 1 -> out_data = D0, D1, D2, D3 on consecutive cycles, in_ready constantly 1.
- Backpressure: out_ready = 0, offer sel = 1 then sel = 3 ->
  - state FULL, in_ready = 0, out_data = D1 held;
  - raise out_ready -> D1 then D3 emitted, in_ready returns to 1.
- Out-of-range: N_IN = 3, SEL_W = 2, DEFAULT = 0xDEADBEEF, accept sel = 3 -> out_data = 0xDEADBEEF, err_sel = 1 and stays 1.
  - Assert clr_err alone -> err_sel = 0.
  - Assert clr_err together with another bad accept -> err_sel stays 1.
- Async reset while FULL -> out_valid and err_sel drop immediately, in_ready = 0 during reset, 1 after release; no stale word is emitted afterwards.
- WIDTH = 8, N_IN = 16, SEL_W = 4 -> each sel 0..15 returns its own byte slice, checked against a scoreboard under random in_valid/out_ready.
